bus_master_if: RTL and testbench

- Master-side bus interface, one instance per master, upstream of the 2-master/4-slave unidirectional bus arbiter.
- Accepts single read/write commands from the local master logic and raises its Req bit to the arbiter.
- Waits for its Ack bit, then drives one transfer on the shared bus and returns a response.
- Handles grant loss (preemption by the higher-priority master), grant and slave timeouts, and the one-cycle release gap the arbiter needs between ownerships.

---
 rtl/bus_master_if.sv | 138 +++++++++++++
 tb/tb_bus_master_if.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - master-side request/grant bus interface with timeout and retry
// One command at a time: request the bus, run one transfer, answer with a single response pulse.
module bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  Req,
  input  logic                  Ack,
  output logic                  bus_valid,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t                state;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [7:0]            wait_cnt;
  logic [3:0]            retry_cnt;
  logic [7:0]            wait_inc;
  logic [3:0]            retry_inc;

  // Saturating increments: the counters must never wrap back under their limits.
  assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Req       <= 1'b0;
      bus_valid <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
            Req       <= 1'b1;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (Ack) begin
            bus_addr  <= lat_addr;
            bus_wdata <= lat_wdata;
            bus_write <= lat_write;
            bus_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= XFER;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_CNT) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              Req       <= 1'b0;
              bus_valid <= 1'b0;
              state     <= RELEASE;
            end
          end
        end
        XFER: begin
          // Completion wins over a grant drop seen in the same cycle.
          if (bus_ready) begin
            if (!bus_write) rsp_rdata <= bus_rdata;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            bus_valid <= 1'b0;
            Req       <= 1'b0;
            state     <= RELEASE;
          end else if (!Ack) begin
            bus_valid <= 1'b0;
            retry_cnt <= retry_inc;
            if (retry_inc < RETRY_LIMIT) begin
              wait_cnt <= '0;
              state    <= REQ;
            end else begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              Req       <= 1'b0;
              state     <= RELEASE;
            end
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_CNT) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              Req       <= 1'b0;
              bus_valid <= 1'b0;
              state     <= RELEASE;
            end
          end
        end
        RELEASE: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - randomized and directed bench for bus_master_if against a cycle timeline model
module tb_bus_master_if;

  localparam int TO = 15;
  localparam int MR = 3;
  localparam int PH_R = 0;
  localparam int PH_X = 1;
  localparam int PH_L = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_error;
  logic [7:0] rsp_rdata;
  logic       Req;
  logic       Ack = 1'b0;
  logic       bus_valid;
  logic       bus_write;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ready = 1'b0;
  logic [7:0] bus_rdata = '0;

  bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .Req(Req), .Ack(Ack),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Scenario: per grant attempt, idle cycles before Ack, then either completion or a grant drop.
  int n_att;
  int att_wait[8];
  int att_drop[8];
  int att_len[8];
  int att_acklow[8];

  int         ph_q[$];
  bit         ack_q[$];
  bit         rdy_q[$];
  bit         exp_err;
  logic [7:0] exp_rdata = '0;

  task automatic push(input int ph, input bit a, input bit r);
    ph_q.push_back(ph);
    ack_q.push_back(a);
    rdy_q.push_back(r);
  endtask

  task automatic set_att(input int k, input int w, input int d, input int l, input int al);
    att_wait[k] = w;
    att_drop[k] = d;
    att_len[k] = l;
    att_acklow[k] = al;
  endtask

  // Expected cycle-by-cycle timeline after acceptance, derived from the waiting/retry rules.
  task automatic build_plan(input bit wr, input logic [7:0] rd);
    int retries;
    bit done;
    ph_q.delete();
    ack_q.delete();
    rdy_q.delete();
    retries = 0;
    done = 0;
    exp_err = 0;
    for (int k = 0; k < n_att && !done; k++) begin
      if (att_wait[k] >= TO) begin
        repeat (TO) push(PH_R, 0, 0);
        exp_err = 1;
        done = 1;
      end else begin
        repeat (att_wait[k]) push(PH_R, 0, 0);
        push(PH_R, 1, 0);
        if (att_len[k] >= TO) begin
          repeat (TO) push(PH_X, 1, 0);
          exp_err = 1;
          done = 1;
        end else begin
          repeat (att_len[k]) push(PH_X, 1, 0);
          if (att_drop[k] == 0) begin
            push(PH_X, att_acklow[k] == 0, 1);
            if (!wr) exp_rdata = rd;
            done = 1;
          end else begin
            push(PH_X, 0, 0);
            retries++;
            if (retries >= MR) begin
              exp_err = 1;
              done = 1;
            end
          end
        end
      end
    end
    if (!done) begin
      repeat (TO) push(PH_R, 0, 0);
      exp_err = 1;
    end
    push(PH_L, 0, 0);
  endtask

  task automatic run_cmd(input string name, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rd);
    logic [3:0]  ctl_exp;
    logic [3:0]  ctl_obs;
    build_plan(wr, rd);
    @(negedge clk);
    compared++;
    if ({cmd_ready, Req, bus_valid, rsp_valid} !== 4'b1000) begin
      mismatched++;
      $display("FAIL %s idle: {cmd_ready,Req,bus_valid,rsp_valid} got %b want 1000", name,
               {cmd_ready, Req, bus_valid, rsp_valid});
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = addr;
    cmd_wdata = wdata;
    Ack = 1'b0;
    bus_ready = 1'b0;
    for (int i = 0; i < ph_q.size(); i++) begin
      @(negedge clk);
      ctl_exp = (ph_q[i] == PH_R) ? 4'b0100 : (ph_q[i] == PH_X) ? 4'b0110 : 4'b0001;
      ctl_obs = {cmd_ready, Req, bus_valid, rsp_valid};
      compared++;
      if (ctl_obs !== ctl_exp) begin
        mismatched++;
        $display("FAIL %s cyc%0d ctl {cmd_ready,Req,bus_valid,rsp_valid}: got %b want %b",
                 name, i + 1, ctl_obs, ctl_exp);
      end
      if (ph_q[i] == PH_X) begin
        compared++;
        if ({bus_write, bus_addr, bus_wdata} !== {wr, addr, wdata}) begin
          mismatched++;
          $display("FAIL %s cyc%0d bus fields: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                   name, i + 1, bus_write, bus_addr, bus_wdata, wr, addr, wdata);
        end
      end
      if (ph_q[i] == PH_L) begin
        compared++;
        if ({rsp_error, rsp_rdata} !== {exp_err, exp_rdata}) begin
          mismatched++;
          $display("FAIL %s response: got err=%b rdata=%h want err=%b rdata=%h",
                   name, rsp_error, rsp_rdata, exp_err, exp_rdata);
        end
      end
      Ack = ack_q[i];
      bus_ready = rdy_q[i];
      bus_rdata = rdy_q[i] ? rd : 8'($urandom);
      if (ph_q[i] == PH_L) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr = 8'($urandom);
        cmd_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({cmd_ready, Req, bus_valid, bus_write, bus_addr, bus_wdata, rsp_valid, rsp_error, rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      mismatched++;
      $display("FAIL reset values: got rdy=%b req=%b bv=%b bw=%b ba=%h bd=%h rv=%b re=%b rd=%h want 1 0 0 0 00 00 0 0 00",
               cmd_ready, Req, bus_valid, bus_write, bus_addr, bus_wdata, rsp_valid, rsp_error, rsp_rdata);
    end
    reset = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_write;
    n_att = 1;
    set_att(0, 2, 0, 1, 0);
    run_cmd("write_8c", 1'b1, 8'h8C, 8'h5A, 8'h00);
  endtask

  task automatic test_read;
    n_att = 1;
    set_att(0, 0, 0, 0, 0);
    run_cmd("read_41", 1'b0, 8'h41, 8'h00, 8'hA7);
  endtask

  task automatic test_timeouts;
    n_att = 1;
    set_att(0, TO, 0, 0, 0);
    run_cmd("req_timeout", 1'b0, 8'h10, 8'h00, 8'h33);
    set_att(0, TO - 1, 0, 0, 0);
    run_cmd("req_edge", 1'b0, 8'h11, 8'h00, 8'h5C);
    set_att(0, 0, 0, TO, 0);
    run_cmd("xfer_timeout", 1'b0, 8'h12, 8'h00, 8'h77);
    set_att(0, 1, 0, TO - 1, 0);
    run_cmd("xfer_edge", 1'b1, 8'hC2, 8'h9D, 8'h00);
  endtask

  task automatic test_preempt;
    n_att = 2;
    set_att(0, 0, 1, 1, 0);
    set_att(1, 1, 0, 0, 0);
    run_cmd("drop_regrant", 1'b0, 8'hE4, 8'h00, 8'h3C);
    n_att = 3;
    set_att(0, 0, 1, 0, 0);
    set_att(1, 2, 1, 1, 0);
    set_att(2, 0, 1, 0, 0);
    run_cmd("drop_x3", 1'b1, 8'h25, 8'hF0, 8'h00);
    set_att(2, 0, 0, 0, 1);
    run_cmd("ready_ack_low", 1'b0, 8'h66, 8'h00, 8'h19);
  endtask

  task automatic test_reset_mid_xfer;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h9A;
    @(negedge clk);
    cmd_valid = 1'b0;
    Ack = 1'b1;
    @(negedge clk);
    compared++;
    if (bus_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset xfer entry: bus_valid got %b want 1", bus_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({cmd_ready, Req, bus_valid, rsp_valid, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      mismatched++;
      $display("FAIL mid_reset after: got rdy=%b req=%b bv=%b rv=%b rd=%h want 1 0 0 0 00",
               cmd_ready, Req, bus_valid, rsp_valid, rsp_rdata);
    end
    reset = 1'b0;
    Ack = 1'b0;
    exp_rdata = '0;
    n_att = 1;
    set_att(0, 0, 0, 0, 0);
    run_cmd("after_reset", 1'b0, 8'h3E, 8'h00, 8'hC5);
  endtask

  task automatic test_back_to_back;
    n_att = 1;
    set_att(0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++)
      run_cmd("b2b", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_random;
    for (int j = 0; j < 40; j++) begin
      n_att = $urandom_range(1, 4);
      for (int k = 0; k < n_att; k++) begin
        att_wait[k] = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 3);
        att_drop[k] = ($urandom_range(0, 2) == 0) ? 1 : 0;
        att_len[k] = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 3);
        att_acklow[k] = $urandom_range(0, 1);
      end
      run_cmd("random", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeouts();
    test_preempt();
    test_reset_mid_xfer();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
